// File: rtl/led_activity.sv
// Per-LED activity driver: stretches 1-cycle event strobes into visible,
// PWM-dimmed LED levels. Optional heartbeat on led[7] when LED_HEARTBEAT_EN is defined.
module led_activity #(
  parameter int STRETCH_CYCLES = 4_000_000,
  parameter int PWM_BITS       = 8,
  parameter int HB_CYCLES      = 50_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          evt,
  input  logic [7:0]          hold,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [7:0]          led
);

  localparam int                  CW       = $clog2(STRETCH_CYCLES + 1);
  localparam logic [CW-1:0]       CNT_LOAD = CW'(STRETCH_CYCLES);
  localparam logic [PWM_BITS-1:0] PWM_MAX  = '1;

  logic [CW-1:0]       cnt [8];
  logic [7:0]          active;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] bright_q;
  logic                pwm_on;
  logic [7:0]          led_d;

  // Retrigger reloads the full stretch; there is no accumulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (evt[i])
          cnt[i] <= CNT_LOAD;
        else if (cnt[i] != '0)
          cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end

  always_comb begin
    active = '0;
    for (int i = 0; i < 8; i++) active[i] = (cnt[i] != '0) | hold[i];
  end

  // Brightness is captured only on the last count of a period so duty changes never glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt  <= '0;
      bright_q <= PWM_MAX;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (pwm_cnt == PWM_MAX) bright_q <= brightness;
    end
  end

  assign pwm_on = (bright_q == PWM_MAX) | (pwm_cnt < bright_q);

`ifdef LED_HEARTBEAT_EN
  logic [31:0] hb_cnt;
  logic        hb;
  logic        unused_ch7;

  always_ff @(posedge clk) begin
    if (reset) begin
      hb_cnt <= '0;
      hb     <= 1'b0;
    end else if (hb_cnt == 32'(HB_CYCLES - 1)) begin
      hb_cnt <= '0;
      hb     <= ~hb;
    end else begin
      hb_cnt <= hb_cnt + 32'd1;
    end
  end

  // Channel 7 is owned by the heartbeat; its event/hold path is dropped.
  assign unused_ch7 = active[7];

  always_comb begin
    led_d    = active & {8{pwm_on}};
    led_d[7] = hb;
  end
`else
  always_comb begin
    led_d = active & {8{pwm_on}};
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) led <= 8'h00;
    else       led <= led_d;
  end

endmodule

// File: tb/tb_led_activity.sv
// Directed testbench for led_activity with STRETCH_CYCLES=4, PWM_BITS=4, HB_CYCLES=8.
module tb_led_activity;

  localparam int STRETCH = 4;
  localparam int PW      = 4;
  localparam int HB      = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    evt;
  logic [7:0]    hold;
  logic [PW-1:0] brightness;
  logic [7:0]    led;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  led_activity #(
    .STRETCH_CYCLES(STRETCH),
    .PWM_BITS      (PW),
    .HB_CYCLES     (HB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .evt       (evt),
    .hold      (hold),
    .brightness(brightness),
    .led       (led)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    evt        = '0;
    hold       = '0;
    brightness = 4'hF;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    do_reset();
    exp = 8'h00;
    n_cmp++;
    if (led !== exp) begin
      n_err++;
      $display("FAIL reset_led: led=%h expected=%h", led, exp);
    end
    for (int j = 1; j <= 4; j++) begin
      tick();
      n_cmp++;
      if (led !== exp) begin
        n_err++;
        $display("FAIL reset_idle e%0d: led=%h expected=%h", j, led, exp);
      end
    end
  endtask

  task automatic test_single_evt(input int ch);
    logic [7:0] exp;
    do_reset();
    evt = 8'(1 << ch);
    tick();
    evt = '0;
    exp = 8'h00;
    n_cmp++;
    if (led !== exp) begin
      n_err++;
      $display("FAIL single_evt ch%0d e0: led=%h expected=%h", ch, led, exp);
    end
    for (int j = 1; j <= 6; j++) begin
      tick();
      exp = (j <= STRETCH) ? 8'(1 << ch) : 8'h00;
      n_cmp++;
      if (led !== exp) begin
        n_err++;
        $display("FAIL single_evt ch%0d e%0d: led=%h expected=%h", ch, j, led, exp);
      end
    end
  endtask

  task automatic test_retrigger();
    logic [7:0] exp;
    do_reset();
    evt = 8'h04;
    tick();
    evt = '0;
    for (int j = 1; j <= 8; j++) begin
      if (j == 2) evt = 8'h04;
      tick();
      evt = '0;
      exp = (j <= 6) ? 8'h04 : 8'h00;
      n_cmp++;
      if (led !== exp) begin
        n_err++;
        $display("FAIL retrigger e%0d: led=%h expected=%h", j, led, exp);
      end
    end
  endtask

  task automatic test_hold();
    logic [7:0] exp;
    do_reset();
    hold = 8'h08;
    for (int j = 0; j <= 10; j++) begin
      if (j == 10) hold = '0;
      tick();
      exp = (j <= 9) ? 8'h08 : 8'h00;
      n_cmp++;
      if (led !== exp) begin
        n_err++;
        $display("FAIL hold e%0d: led=%h expected=%h", j, led, exp);
      end
    end
    // hold on edges 0..9 with an event at edge 8: lit through edge 12 from the residue.
    do_reset();
    hold = 8'h08;
    for (int j = 0; j <= 14; j++) begin
      if (j == 10) hold = '0;
      evt = (j == 8) ? 8'h08 : 8'h00;
      tick();
      evt = '0;
      exp = (j <= 12) ? 8'h08 : 8'h00;
      n_cmp++;
      if (led !== exp) begin
        n_err++;
        $display("FAIL hold_evt e%0d: led=%h expected=%h", j, led, exp);
      end
    end
  endtask

  task automatic test_pwm();
    logic [7:0] exp;
    logic       b;
    do_reset();
    hold = 8'h02;
    for (int e = 1; e <= 64; e++) begin
      if (e == 6)  brightness = 4'd4;
      if (e == 25) brightness = 4'd0;
      if (e == 41) brightness = 4'hF;
      tick();
      if (e <= 16)      b = 1'b1;
      else if (e <= 32) b = ((e - 17) < 4);
      else if (e <= 48) b = 1'b0;
      else              b = 1'b1;
      exp = {6'b0, b, 1'b0};
      n_cmp++;
      if (led !== exp) begin
        n_err++;
        $display("FAIL pwm e%0d: led=%h expected=%h", e, led, exp);
      end
    end
    hold = '0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    do_reset();
    evt = 8'h20;
    tick();
    evt = '0;
    for (int j = 1; j <= 9; j++) begin
      if (j == 3) reset = 1'b1;
      tick();
      reset = 1'b0;
      exp = (j <= 2) ? 8'h20 : 8'h00;
      n_cmp++;
      if (led !== exp) begin
        n_err++;
        $display("FAIL reset_mid e%0d: led=%h expected=%h", j, led, exp);
      end
    end
  endtask

  task automatic test_multi_channel();
    logic [7:0] exp;
    do_reset();
    evt = 8'h3C;
    tick();
    evt = '0;
    for (int j = 1; j <= 6; j++) begin
      if (j == 2) evt = 8'h01;
      tick();
      evt = '0;
      if (j <= STRETCH) exp = 8'h3C;
      else              exp = 8'h00;
      if (j >= 3 && j <= 6) exp = exp | 8'h01;
      n_cmp++;
      if (led !== exp) begin
        n_err++;
        $display("FAIL multi_channel e%0d: led=%h expected=%h", j, led, exp);
      end
    end
  endtask

`ifdef LED_HEARTBEAT_EN
  task automatic test_heartbeat();
    logic [7:0] exp;
    do_reset();
    evt  = 8'h80;
    hold = 8'h80;
    brightness = 4'd0;
    for (int e = 1; e <= 34; e++) begin
      tick();
      exp = {1'(((e - 1) / HB) % 2), 7'b0};
      n_cmp++;
      if (led !== exp) begin
        n_err++;
        $display("FAIL heartbeat e%0d: led=%h expected=%h", e, led, exp);
      end
    end
    evt  = '0;
    hold = '0;
  endtask
`endif

  initial begin
    reset      = 1'b1;
    evt        = '0;
    hold       = '0;
    brightness = 4'hF;
    test_reset();
    test_single_evt(0);
    test_retrigger();
    test_hold();
    test_pwm();
    test_reset_mid();
    test_multi_channel();
`ifdef LED_HEARTBEAT_EN
    test_heartbeat();
`else
    test_single_evt(7);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
